// File: rtl/dmemory_be.sv
// dmemory_be
// Byte-addressable data memory for the cinco load/store stage.
// Supports RV32I sb/sh/sw stores through per-byte lane enables, lb/lh/lw/lbu/lhu
// loads with sign or zero extension, and range, alignment and funct3 checks.
// Requests use a valid/ready handshake. Each accepted request produces one
// registered response one cycle later. After reset the whole array is cleared
// one word per cycle before any request is accepted.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   request present
//   req_ready   block can accept a request this cycle
//   req_we      1 = store, 0 = load
//   req_funct3  RV32I access size and signedness
//   req_addr    byte address
//   req_wdata   right-aligned store data
//   rsp_valid   one-cycle pulse carrying the response
//   rsp_rdata   extended load result, 0 for stores and errors
//   rsp_err     misaligned, out of range or illegal funct3
module dmemory_be #(
  parameter int unsigned BYTES     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DEPTH = BYTES / 4;
  localparam int unsigned AW    = $clog2(BYTES);
  localparam int unsigned IW    = AW - 2;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t        state_q;
  logic [IW-1:0] clrCnt_q;
  logic          reqReady_q;
  logic          rspValid_q;
  logic          rspErr_q;
  logic [31:0]   rspRdata_q;

  logic [31:0]   mem [DEPTH];

  logic [31:0]   off;
  logic [1:0]    lane;
  logic [IW-1:0] wordIdx;
  logic          accept;
  logic          reqErr;
  logic [31:0]   rdata_d;
  logic [31:0]   shifted;

  logic [3:0]    memBe;
  logic [IW-1:0] memIdx;
  logic [31:0]   memWdata;

  assign off     = req_addr - BASE_ADDR;
  assign lane    = off[1:0];
  assign wordIdx = off[AW-1:2];
  assign accept  = req_valid & reqReady_q;

  // Error decode: range, alignment and funct3 legality for the access kind.
  always_comb begin
    reqErr = 1'b0;
    if (off >= 32'(BYTES)) reqErr = 1'b1;
    case (req_funct3)
      3'b000:         ;
      3'b001:         if (lane[0]) reqErr = 1'b1;
      3'b010:         if (lane != 2'b00) reqErr = 1'b1;
      3'b100:         if (req_we) reqErr = 1'b1;
      3'b101:         if (req_we || lane[0]) reqErr = 1'b1;
      default:        reqErr = 1'b1;
    endcase
  end

  // Load path: shift the addressed word down to the lane, then extend.
  always_comb begin
    shifted = 32'h0;
    rdata_d = 32'h0;
    if (!reqErr && !req_we) begin
      shifted = mem[wordIdx] >> {lane, 3'b000};
      case (req_funct3)
        3'b000:  rdata_d = {{24{shifted[7]}}, shifted[7:0]};
        3'b001:  rdata_d = {{16{shifted[15]}}, shifted[15:0]};
        3'b100:  rdata_d = {24'h0, shifted[7:0]};
        3'b101:  rdata_d = {16'h0, shifted[15:0]};
        default: rdata_d = shifted;
      endcase
    end
  end

  // Array write port: zero-fill during INIT, byte-lane stores once READY.
  // Store data is replicated across lanes so the enables alone pick the bytes.
  always_comb begin
    memBe    = 4'b0000;
    memIdx   = clrCnt_q;
    memWdata = 32'h0;
    if (state_q == INIT) begin
      memBe = 4'b1111;
    end else if (accept && req_we && !reqErr) begin
      memIdx = wordIdx;
      case (req_funct3)
        3'b000: begin
          memBe    = 4'b0001 << lane;
          memWdata = {4{req_wdata[7:0]}};
        end
        3'b001: begin
          memBe    = 4'b0011 << lane;
          memWdata = {2{req_wdata[15:0]}};
        end
        default: begin
          memBe    = 4'b1111;
          memWdata = req_wdata;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (memBe[b]) mem[memIdx][8*b +: 8] <= memWdata[8*b +: 8];
    end
  end

  // Control FSM with registered handshake and response outputs.
  // Response data and error hold their value between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      clrCnt_q   <= '0;
      reqReady_q <= 1'b0;
      rspValid_q <= 1'b0;
      rspErr_q   <= 1'b0;
      rspRdata_q <= 32'h0;
    end else begin
      rspValid_q <= 1'b0;
      case (state_q)
        INIT: begin
          clrCnt_q <= clrCnt_q + 1'b1;
          if (clrCnt_q == LAST_IDX) begin
            state_q    <= READY;
            reqReady_q <= 1'b1;
          end
        end
        READY: begin
          if (accept) begin
            rspValid_q <= 1'b1;
            rspErr_q   <= reqErr;
            rspRdata_q <= rdata_d;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign req_ready = reqReady_q;
  assign rsp_valid = rspValid_q;
  assign rsp_err   = rspErr_q;
  assign rsp_rdata = rspRdata_q;

endmodule

// File: tb/tb_dmemory_be.sv
// Directed testbench for dmemory_be with BYTES=64 and BASE_ADDR=0x1000.
// All addresses are written as base plus offset.
module tb_dmemory_be;

  localparam logic [31:0] B = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int testCount = 0;
  int failCount = 0;

  dmemory_be #(.BYTES(64), .BASE_ADDR(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares {rsp_valid, rsp_err, rsp_rdata} or any other packed value.
  task automatic checkOutput(input string tag, input logic [33:0] observed,
                             input logic [33:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Presents one request for exactly one rising edge, then samples #1 later.
  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Counts edges until req_ready rises, bounded; also notes any stray response.
  task automatic waitReady(output int n, output logic sawRsp);
    n = 0;
    sawRsp = 1'b0;
    while (!req_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (rsp_valid) sawRsp = 1'b1;
    end
  endtask

  int   nCycles;
  logic stray;

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b0, 1'b0, 32'h0});
    checkOutput("reset_ready", {33'h0, req_ready}, 34'h0);
    rst_n = 1'b1;

    waitReady(nCycles, stray);
    checkOutput("init_cycles", 34'(nCycles), 34'd16);

    applyStimulus(1'b0, 3'b010, B + 32'h3C, 32'h0);
    checkOutput("lw_3c_after_init", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0});
    @(posedge clk); #1;
    checkOutput("idle_no_rsp", {33'h0, rsp_valid}, 34'h0);

    // Extension and byte-lane stores, back to back
    applyStimulus(1'b1, 3'b010, B + 32'h08, 32'hDEADBEEF);
    checkOutput("sw_08", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0});
    applyStimulus(1'b0, 3'b000, B + 32'h08, 32'h0);
    checkOutput("lb_08", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'hFFFFFFEF});
    applyStimulus(1'b0, 3'b100, B + 32'h0B, 32'h0);
    checkOutput("lbu_0b", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h000000DE});
    applyStimulus(1'b0, 3'b001, B + 32'h0A, 32'h0);
    checkOutput("lh_0a", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'hFFFFDEAD});
    applyStimulus(1'b0, 3'b101, B + 32'h08, 32'h0);
    checkOutput("lhu_08", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0000BEEF});
    applyStimulus(1'b1, 3'b000, B + 32'h09, 32'h000000AA);
    checkOutput("sb_09", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0});
    applyStimulus(1'b1, 3'b001, B + 32'h0A, 32'h00001234);
    checkOutput("sh_0a", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0});
    applyStimulus(1'b0, 3'b010, B + 32'h08, 32'h0);
    checkOutput("lw_08_lanes", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h1234AAEF});
    @(posedge clk); #1;
    checkOutput("hold_after_lw", {rsp_valid, rsp_err, rsp_rdata}, {1'b0, 1'b0, 32'h1234AAEF});

    // Word 1 as a reference for error cases
    applyStimulus(1'b1, 3'b010, B + 32'h04, 32'h0BADF00D);
    checkOutput("sw_04", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0});
    applyStimulus(1'b0, 3'b001, B + 32'h06, 32'h0);
    checkOutput("lh_06", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h00000BAD});
    applyStimulus(1'b0, 3'b000, B + 32'h05, 32'h0);
    checkOutput("lb_05", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'hFFFFFFF0});

    applyStimulus(1'b0, 3'b010, B + 32'h02, 32'h0);
    checkOutput("lw_02_misal", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 32'h0});
    applyStimulus(1'b0, 3'b010, B + 32'h04, 32'h0);
    checkOutput("lw_04_a", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0BADF00D});
    applyStimulus(1'b1, 3'b001, B + 32'h05, 32'hFFFFFFFF);
    checkOutput("sh_05_misal", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 32'h0});
    applyStimulus(1'b0, 3'b010, B + 32'h04, 32'h0);
    checkOutput("lw_04_b", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0BADF00D});
    applyStimulus(1'b0, 3'b011, B + 32'h04, 32'h0);
    checkOutput("f3_011", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 32'h0});
    applyStimulus(1'b0, 3'b010, B + 32'h04, 32'h0);
    checkOutput("lw_04_c", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0BADF00D});
    applyStimulus(1'b1, 3'b100, B + 32'h04, 32'hFFFFFFFF);
    checkOutput("store_f3_100", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 32'h0});
    applyStimulus(1'b0, 3'b010, B + 32'h04, 32'h0);
    checkOutput("lw_04_d", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0BADF00D});

    // Range checks around the window
    applyStimulus(1'b0, 3'b010, B + 32'h40, 32'h0);
    checkOutput("lw_above", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 32'h0});
    applyStimulus(1'b0, 3'b010, B - 32'h04, 32'h0);
    checkOutput("lw_below", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 32'h0});
    applyStimulus(1'b1, 3'b010, B + 32'h3C, 32'hCAFE0001);
    checkOutput("sw_3c", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0});
    applyStimulus(1'b0, 3'b010, B + 32'h3C, 32'h0);
    checkOutput("lw_3c_top", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'hCAFE0001});

    // Reset with a response in flight
    applyStimulus(1'b1, 3'b010, B + 32'h10, 32'h55AA55AA);
    checkOutput("sw_10", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0});
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b0, 1'b0, 32'h0});
    checkOutput("async_reset_ready", {33'h0, req_ready}, 34'h0);
    repeat (2) @(posedge clk);
    #1;
    // A store held during INIT must be ignored
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = B + 32'h10;
    req_wdata  = 32'hFFFFFFFF;
    rst_n = 1'b1;
    waitReady(nCycles, stray);
    req_valid = 1'b0;
    checkOutput("reinit_cycles", 34'(nCycles), 34'd16);
    checkOutput("no_rsp_in_init", {33'h0, stray}, 34'h0);
    applyStimulus(1'b0, 3'b010, B + 32'h10, 32'h0);
    checkOutput("lw_10_cleared", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0});
    applyStimulus(1'b0, 3'b010, B + 32'h3C, 32'h0);
    checkOutput("lw_3c_cleared", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0});

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
